// File: rtl/parking_gate_ctrl.sv
// Car park entry/exit gate controller: serial access code check, occupancy
// tracking, entry timeout, retry lockout and blinking gate lamps.
module parking_gate_ctrl #(
    parameter int unsigned CAPACITY      = 16,
    parameter int unsigned CNT_W         = 5,
    parameter int unsigned DIGIT_W       = 4,
    parameter int unsigned NUM_DIGITS    = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] PASS_CODE = 16'h2654,
    parameter int unsigned ENTRY_TIMEOUT = 64,
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned LOCK_CYCLES   = 128,
    parameter int unsigned BLINK_DIV     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sensor_entrance,
    input  logic               sensor_exit,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    output logic               GREEN_LED,
    output logic               RED_LED,
    output logic               gate_open,
    output logic               full,
    output logic [CNT_W-1:0]   occupancy,
    output logic [2:0]         state_out,
    output logic               alarm
);

    localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS) + 1;
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES) + 1;
    localparam int unsigned TMR_MAX = (ENTRY_TIMEOUT > LOCK_CYCLES) ? ENTRY_TIMEOUT : LOCK_CYCLES;
    localparam int unsigned TMR_W  = $clog2(TMR_MAX) + 1;
    localparam int unsigned BLK_W  = $clog2(BLINK_DIV) + 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TRY_W-1:0] TRIES_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CAP        = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANTED = 3'd3,
        ST_DENIED  = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                ent_q, ent_prev_q, ext_q, ext_prev_q;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic                blink_q, blink_d;
    logic                green_q, green_d, red_q, red_d, gate_q, gate_d, alarm_q, alarm_d;
    logic                ent_edge_c, ext_edge_c, full_c, occ_inc_c, occ_dec_c;

    assign ent_edge_c = ent_q & ~ent_prev_q;
    assign ext_edge_c = ext_q & ~ext_prev_q;
    assign full_c     = (occ_q == CAP);

    // Next-state, datapath and lamp logic; lamps are computed from next-state
    // values so the registered outputs line up with state_q.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        idx_d     = idx_q;
        tries_d   = tries_q;
        timer_d   = timer_q;
        occ_inc_c = 1'b0;
        occ_dec_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                occ_dec_c = ext_edge_c;
                if (ent_edge_c && !full_c) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end
            ST_ENTRY: begin
                occ_dec_c = ext_edge_c;
                timer_d   = timer_q + TMR_W'(1);
                if (digit_valid) begin
                    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                        if (idx_q == IDX_W'(i)) code_d[i*DIGIT_W +: DIGIT_W] = digit_in;
                    end
                    idx_d = idx_q + IDX_W'(1);
                end
                if (digit_valid && idx_q == IDX_LAST) state_d = ST_CHECK;
                else if (timer_q == TO_LAST)        state_d = ST_IDLE;
            end
            ST_CHECK: begin
                if (code_q == PASS_CODE) begin
                    state_d = ST_GRANTED;
                    tries_d = '0;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                    if (tries_q == TRIES_LAST) begin
                        state_d = ST_LOCKOUT;
                        timer_d = '0;
                    end else begin
                        state_d = ST_DENIED;
                    end
                end
            end
            ST_GRANTED: begin
                // Simultaneous edges mean a second car followed the first in.
                if (ext_edge_c && ent_edge_c) begin
                    state_d = ST_DENIED;
                end else if (ext_edge_c) begin
                    state_d   = ST_IDLE;
                    occ_inc_c = 1'b1;
                end
            end
            ST_DENIED: begin
                occ_dec_c = ext_edge_c;
                if (ext_edge_c) begin
                    state_d = ST_IDLE;
                end else if (ent_edge_c) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end
            ST_LOCKOUT: begin
                occ_dec_c = ext_edge_c;
                timer_d   = timer_q + TMR_W'(1);
                if (timer_q == LOCK_LAST) begin
                    state_d = ST_IDLE;
                    tries_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        occ_d = occ_q;
        if (occ_inc_c && occ_q != CAP)       occ_d = occ_q + CNT_W'(1);
        else if (occ_dec_c && occ_q != '0)   occ_d = occ_q - CNT_W'(1);

        blk_cnt_d = blk_cnt_q + BLK_W'(1);
        blink_d   = blink_q;
        if (state_d != state_q) begin
            blk_cnt_d = '0;
            blink_d   = 1'b1;
        end else if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            blink_d   = ~blink_q;
        end

        green_d = (state_d == ST_GRANTED) && blink_d;
        gate_d  = (state_d == ST_GRANTED);
        alarm_d = (state_d == ST_LOCKOUT);
        red_d   = (state_d == ST_ENTRY)
               || (((state_d == ST_DENIED) || (state_d == ST_LOCKOUT)) && blink_d)
               || ((state_d == ST_IDLE) && full_c && ent_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ent_q      <= 1'b0;
            ent_prev_q <= 1'b0;
            ext_q      <= 1'b0;
            ext_prev_q <= 1'b0;
            code_q     <= '0;
            idx_q      <= '0;
            tries_q    <= '0;
            timer_q    <= '0;
            occ_q      <= '0;
            blk_cnt_q  <= '0;
            blink_q    <= 1'b0;
            green_q    <= 1'b0;
            red_q      <= 1'b0;
            gate_q     <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ent_q      <= sensor_entrance;
            ent_prev_q <= ent_q;
            ext_q      <= sensor_exit;
            ext_prev_q <= ext_q;
            code_q     <= code_d;
            idx_q      <= idx_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            occ_q      <= occ_d;
            blk_cnt_q  <= blk_cnt_d;
            blink_q    <= blink_d;
            green_q    <= green_d;
            red_q      <= red_d;
            gate_q     <= gate_d;
            alarm_q    <= alarm_d;
        end
    end

    assign GREEN_LED = green_q;
    assign RED_LED   = red_q;
    assign gate_open = gate_q;
    assign alarm     = alarm_q;
    assign occupancy = occ_q;
    assign full      = full_c;
    assign state_out = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with a two-slot car park.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_entrance = 1'b0;
    logic       sensor_exit = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = '0;
    logic       GREEN_LED, RED_LED, gate_open, full, alarm;
    logic [4:0] occupancy;
    logic [2:0] state_out;

    int errors = 0;
    int checks = 0;

    parking_gate_ctrl #(.CAPACITY(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
        .digit_valid(digit_valid), .digit_in(digit_in),
        .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .gate_open(gate_open),
        .full(full), .occupancy(occupancy), .state_out(state_out), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising edge on one sensor; the FSM reacts on the second clock.
    task automatic pulse(input bit use_exit);
        tick();
        if (use_exit) sensor_exit = 1'b1; else sensor_entrance = 1'b1;
        tick();
        tick();
        sensor_exit = 1'b0;
        sensor_entrance = 1'b0;
    endtask

    task automatic send_code(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] ds [4];
        ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
        for (int i = 0; i < 4; i++) begin
            digit_valid = 1'b1;
            digit_in = ds[i];
            tick();
            digit_valid = 1'b0;
        end
    endtask

    task automatic admit_car();
        pulse(1'b0);
        send_code(4'd4, 4'd5, 4'd6, 4'd2);
        tick();
        pulse(1'b1);
    endtask

    task automatic wrong_code();
        pulse(1'b0);
        send_code(4'd1, 4'd1, 4'd1, 4'd1);
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_leds", {29'd0, GREEN_LED, RED_LED, gate_open}, 32'd0);
        chk("rst_alarm_full", {30'd0, alarm, full}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Correct code walk-through
        pulse(1'b0);
        chk("entry_state", 32'(state_out), 32'd1);
        chk("entry_red", 32'(RED_LED), 32'd1);
        send_code(4'd4, 4'd5, 4'd6, 4'd2);
        chk("check_state", 32'(state_out), 32'd2);
        tick();
        chk("granted_state", 32'(state_out), 32'd3);
        chk("granted_gate", 32'(gate_open), 32'd1);
        chk("granted_green", 32'(GREEN_LED), 32'd1);
        chk("granted_occ", 32'(occupancy), 32'd0);
        pulse(1'b1);
        chk("admit1_state", 32'(state_out), 32'd0);
        chk("admit1_occ", 32'(occupancy), 32'd1);
        chk("admit1_gate", 32'(gate_open), 32'd0);

        // Fill to capacity
        admit_car();
        chk("fill_occ", 32'(occupancy), 32'd2);
        chk("fill_full", 32'(full), 32'd1);
        pulse(1'b0);
        chk("full_stay_idle", 32'(state_out), 32'd0);
        chk("full_red", 32'(RED_LED), 32'd1);
        pulse(1'b1);
        chk("depart_occ", 32'(occupancy), 32'd1);
        chk("depart_full", 32'(full), 32'd0);
        pulse(1'b1);
        chk("depart2_occ", 32'(occupancy), 32'd0);

        // Three wrong codes lead to lockout
        wrong_code();
        chk("wrong1_state", 32'(state_out), 32'd4);
        chk("wrong1_red", 32'(RED_LED), 32'd1);
        wrong_code();
        chk("wrong2_state", 32'(state_out), 32'd4);
        wrong_code();
        chk("lock_state", 32'(state_out), 32'd5);
        chk("lock_alarm", 32'(alarm), 32'd1);
        for (int i = 1; i <= 127; i++) begin
            tick();
            if (i == 7) chk("lock_blink_on", 32'(RED_LED), 32'd1);
            if (i == 8) chk("lock_blink_off", 32'(RED_LED), 32'd0);
        end
        chk("lock_last_state", 32'(state_out), 32'd5);
        chk("lock_last_alarm", 32'(alarm), 32'd1);
        tick();
        chk("unlock_state", 32'(state_out), 32'd0);
        chk("unlock_alarm", 32'(alarm), 32'd0);

        // Correct code accepted after lockout, then tailgating
        pulse(1'b0);
        send_code(4'd4, 4'd5, 4'd6, 4'd2);
        tick();
        chk("postlock_granted", 32'(state_out), 32'd3);
        tick();
        sensor_entrance = 1'b1;
        sensor_exit = 1'b1;
        tick();
        tick();
        sensor_entrance = 1'b0;
        sensor_exit = 1'b0;
        chk("tailgate_state", 32'(state_out), 32'd4);
        chk("tailgate_occ", 32'(occupancy), 32'd0);
        pulse(1'b1);
        chk("denied_exit_state", 32'(state_out), 32'd0);
        chk("occ_saturate", 32'(occupancy), 32'd0);

        // Timeout keeps the try count: one wrong, timeout, two wrong -> lockout
        wrong_code();
        chk("pre_to_wrong", 32'(state_out), 32'd4);
        pulse(1'b1);
        pulse(1'b0);
        digit_valid = 1'b1; digit_in = 4'd4; tick();
        digit_in = 4'd5; tick();
        digit_valid = 1'b0;
        repeat (61) tick();
        chk("to_still_entry", 32'(state_out), 32'd1);
        tick();
        chk("to_idle", 32'(state_out), 32'd0);
        wrong_code();
        chk("post_to_wrong", 32'(state_out), 32'd4);
        wrong_code();
        chk("post_to_lock", 32'(state_out), 32'd5);
        repeat (128) tick();
        chk("lock2_release", 32'(state_out), 32'd0);

        // Asynchronous reset while granted with one car parked
        admit_car();
        pulse(1'b0);
        send_code(4'd4, 4'd5, 4'd6, 4'd2);
        tick();
        chk("pre_rst_state", 32'(state_out), 32'd3);
        chk("pre_rst_occ", 32'(occupancy), 32'd1);
        repeat (8) tick();
        chk("green_blink_off", 32'(GREEN_LED), 32'd0);
        chk("gate_steady", 32'(gate_open), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_gate", 32'(gate_open), 32'd0);
        chk("arst_state", 32'(state_out), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(state_out), 32'd0);
        chk("post_rst_occ", 32'(occupancy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
